preif_fetch_ctrl: RTL and testbench
===================================

PREIF_FETCH_CTRL -- requirements
Module: preif_fetch_ctrl

Interface
REQ-001 Parameter FETCH_W, default 2, instructions per fetch packet; legal values 1, 2 and 4.
REQ-002 Parameter MAX_OUTST, default 2, maximum accepted-but-unreturned fetch requests; range 1..7.
REQ-003 Parameter RESET_PC, default 32'h1c000000, fetch PC after reset.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 stall_i / stall_pc_i  in  1/32  hold-fetch request and the PC to resume at.
REQ-008 excep_en_i / excep_pc_i, ertn_en_i / ertn_pc_i, refetch_en_i / refetch_pc_i  in  1/32 each  exception entry, exception return, TLB refetch redirects.
REQ-009 branch_en_i / branch_pc_i  in  1/32  decode-stage branch redirect.
REQ-010 flush_i  in  1  pipeline flush, coincident with any exception, ertn or refetch redirect.
REQ-011 interrupt_en_i  in  1  pending interrupt to tag onto the fetch stream.
REQ-012 cpu_error_i  in  1  fatal error; stops all new fetch.
REQ-013 next_allowin_i  in  1  IF stage can accept a packet.
REQ-014 inst_sram_req_o  out  1 / inst_sram_addr_o  out  32 / inst_sram_addr_ok_i  in  1 / inst_sram_data_ok_i  in  1  request-channel handshake.
REQ-015 to_next_valid_o  out  1 / to_next_pc_o  out  32 / to_next_mask_o  out  FETCH_W / to_next_int_o  out  1  packet handed to IF.
REQ-016 discard_o  out  1  high in a cycle where the concurrent data_ok belongs to a cancelled request.

Function
REQ-017 The block shall hold the fetch PC in an internal 32-bit register, pc_q.
REQ-018 Redirect priority, highest first: stall, exception, ertn, refetch, branch, sequential.
REQ-019 Sequential next PC = (pc_q with low log2(FETCH_W*4) bits cleared) + FETCH_W*4, 32-bit wrap.
REQ-020 inst_sram_addr_o shall equal pc_q with the low 2 bits cleared.
REQ-021 to_next_mask_o lane k shall be 1 iff k >= pc_q[log2(FETCH_W*4)-1:2]; all lanes are 1 when FETCH_W=1.
REQ-022 inst_sram_req_o = rst_n & next_allowin_i & ~stall_i & ~cpu_error_i & ~flush_i & ~int_pend & (outst < MAX_OUTST), OR'd with req_hold.
REQ-023 req_hold: once req is high without addr_ok, req and addr shall stay stable until addr_ok, regardless of redirect, stall or allowin.
REQ-024 A redirect arriving while req_hold is set shall be latched in a one-entry pending-redirect register, newer higher-priority redirects overwriting it.
REQ-025 That held request shall be marked cancelled; after its addr_ok, pc_q shall load the pending target, not the sequential PC.
REQ-026 On req & addr_ok with no cancel, the block shall pulse to_next_valid_o for one cycle with that PC and mask, and load pc_q with the next PC.
REQ-027 outst is a 3-bit counter: +1 on req & addr_ok, -1 on data_ok, unchanged when both occur in the same cycle; it shall never exceed MAX_OUTST nor go below 0.
REQ-028 On flush_i, discard_cnt shall load the number of requests not yet returned, counting a held cancelled request and excluding a data_ok in the same cycle.
REQ-029 While discard_cnt > 0, each data_ok shall assert discard_o and decrement discard_cnt.
REQ-030 interrupt_en_i shall set int_pend; with int_pend set and next_allowin_i high, the block shall emit a packet with to_next_valid_o = 1 and to_next_int_o = 1, raise no request, then clear int_pend.
REQ-031 A flush in the same cycle clears int_pend and suppresses the interrupt packet.
REQ-032 With stall_i high, pc_q shall load stall_pc_i and no new request shall start.
REQ-033 cpu_error_i shall block new requests and interrupt packets; a held request shall still complete its handshake.

Reset
REQ-034 On rst_n = 0 at a clock edge: pc_q = RESET_PC, outst = 0, discard_cnt = 0, req_hold = 0, pending redirect cleared, int_pend = 0.
REQ-035 During reset all outputs shall be 0 except inst_sram_addr_o, which shall equal RESET_PC.

Verification
REQ-036 FETCH_W=2; reset release with addr_ok always 1 -> requests at 1c000000, 1c000008, 1c000010, each with mask 2'b11.
REQ-037 Branch to 1c000104 -> packet with pc 1c000104 and mask 2'b10, then next request at 1c000108.
REQ-038 Request held with addr_ok = 0 for 3 cycles while branch_en_i pulses -> addr stable for 3 cycles, no valid for the held request, next request at the branch target.
REQ-039 MAX_OUTST=2 with 2 requests outstanding and no data_ok -> req low until data_ok; outst never reaches 3.
REQ-040 2 requests outstanding, then flush_i with excep_pc 1c008000 -> next 2 data_ok have discard_o = 1, then a fresh request at 1c008000.
REQ-041 interrupt_en_i with next_allowin_i = 1 -> one int packet with no req; same stimulus with flush_i -> no int packet.

Source files
------------

// File: rtl/preif_fetch_ctrl.sv
// Pre-IF fetch controller: picks the next fetch PC, drives the instruction SRAM request channel,
// tracks outstanding requests, drops responses of cancelled requests and injects interrupt packets.
module preif_fetch_ctrl #(
  parameter int unsigned FETCH_W   = 2,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic [31:0]        stall_pc_i,
  input  logic               excep_en_i,
  input  logic [31:0]        excep_pc_i,
  input  logic               ertn_en_i,
  input  logic [31:0]        ertn_pc_i,
  input  logic               refetch_en_i,
  input  logic [31:0]        refetch_pc_i,
  input  logic               branch_en_i,
  input  logic [31:0]        branch_pc_i,
  input  logic               flush_i,
  input  logic               interrupt_en_i,
  input  logic               cpu_error_i,
  input  logic               next_allowin_i,
  output logic               inst_sram_req_o,
  output logic [31:0]        inst_sram_addr_o,
  input  logic               inst_sram_addr_ok_i,
  input  logic               inst_sram_data_ok_i,
  output logic               to_next_valid_o,
  output logic [31:0]        to_next_pc_o,
  output logic [FETCH_W-1:0] to_next_mask_o,
  output logic               to_next_int_o,
  output logic               discard_o
);

  localparam int unsigned BLK_BYTES   = FETCH_W * 4;
  localparam logic [31:0] BLK_MASK    = 32'(BLK_BYTES - 1);
  localparam logic [2:0]  MAX_OUTST_C = 3'(MAX_OUTST);

  logic [31:0]        pc_q;
  logic [31:0]        pend_pc_r;
  logic               pend_vld_r;
  logic               req_hold_r;
  logic               int_pend_r;
  logic [2:0]         outst_r;
  logic [2:0]         discard_cnt_r;
  logic               to_next_valid_r;
  logic [31:0]        to_next_pc_r;
  logic [FETCH_W-1:0] to_next_mask_r;
  logic               to_next_int_r;

  logic               redir_en_s;
  logic [31:0]        redir_pc_s;
  logic [31:0]        seq_pc_s;
  logic [FETCH_W-1:0] mask_s;
  logic               req_new_s;
  logic               req_s;
  logic               hs_s;
  logic               hold_s;
  logic               cancel_s;
  logic               dok_s;
  logic               int_fire_s;
  logic [2:0]         outst_nxt_s;
  logic [2:0]         unret_s;

  // Redirect source selection, highest priority first.
  always_comb begin
    redir_en_s = 1'b1;
    redir_pc_s = 32'h0000_0000;
    if (stall_i) begin
      redir_pc_s = stall_pc_i;
    end else if (excep_en_i) begin
      redir_pc_s = excep_pc_i;
    end else if (ertn_en_i) begin
      redir_pc_s = ertn_pc_i;
    end else if (refetch_en_i) begin
      redir_pc_s = refetch_pc_i;
    end else if (branch_en_i) begin
      redir_pc_s = branch_pc_i;
    end else begin
      redir_en_s = 1'b0;
    end
  end

  // Lane valid mask: lanes before the entry slot of the packet are dropped.
  always_comb begin
    mask_s = {FETCH_W{1'b0}};
    for (int k = 0; k < int'(FETCH_W); k++) begin
      if (32'(k) >= ((pc_q & BLK_MASK) >> 2)) begin
        mask_s[k] = 1'b1;
      end else begin
        mask_s[k] = 1'b0;
      end
    end
  end

  assign seq_pc_s    = (pc_q & ~BLK_MASK) + 32'(BLK_BYTES);
  assign req_new_s   = rst_n & next_allowin_i & ~stall_i & ~cpu_error_i & ~flush_i
                     & ~int_pend_r & (outst_r < MAX_OUTST_C);
  assign req_s       = rst_n & (req_new_s | req_hold_r);
  assign hs_s        = req_s & inst_sram_addr_ok_i;
  assign hold_s      = req_s & ~inst_sram_addr_ok_i;
  // A request is dropped if a redirect is pending for it or lands in its handshake cycle.
  assign cancel_s    = pend_vld_r | redir_en_s;
  assign dok_s       = inst_sram_data_ok_i & (outst_r != 3'd0);
  assign int_fire_s  = rst_n & int_pend_r & next_allowin_i & ~cpu_error_i & ~flush_i & ~req_hold_r;
  assign outst_nxt_s = outst_r + {2'b00, hs_s} - {2'b00, dok_s};
  assign unret_s     = outst_r + {2'b00, req_hold_r} - {2'b00, dok_s};

  // Request bookkeeping: hold flag, outstanding count, discard count, interrupt pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_hold_r    <= 1'b0;
      outst_r       <= 3'd0;
      discard_cnt_r <= 3'd0;
      int_pend_r    <= 1'b0;
    end else begin
      req_hold_r <= hold_s;
      outst_r    <= outst_nxt_s;
      if (flush_i) begin
        discard_cnt_r <= unret_s;
      end else if (inst_sram_data_ok_i && (discard_cnt_r != 3'd0)) begin
        discard_cnt_r <= discard_cnt_r - 3'd1;
      end
      if (flush_i || int_fire_s) begin
        int_pend_r <= 1'b0;
      end else if (interrupt_en_i) begin
        int_pend_r <= 1'b1;
      end
    end
  end

  // Fetch PC and the one-entry pending redirect captured while the bus request is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_vld_r <= 1'b0;
      pend_pc_r  <= 32'h0000_0000;
    end else if (hs_s) begin
      pend_vld_r <= 1'b0;
      if (redir_en_s) begin
        pc_q <= redir_pc_s;
      end else if (pend_vld_r) begin
        pc_q <= pend_pc_r;
      end else begin
        pc_q <= seq_pc_s;
      end
    end else if (hold_s) begin
      if (redir_en_s) begin
        pend_vld_r <= 1'b1;
        pend_pc_r  <= redir_pc_s;
      end
    end else if (redir_en_s) begin
      pc_q <= redir_pc_s;
    end
  end

  // Packet handed to IF, one cycle after the accepted request or the interrupt slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_next_valid_r <= 1'b0;
      to_next_pc_r    <= 32'h0000_0000;
      to_next_mask_r  <= {FETCH_W{1'b0}};
      to_next_int_r   <= 1'b0;
    end else begin
      to_next_valid_r <= (hs_s & ~cancel_s) | int_fire_s;
      to_next_pc_r    <= pc_q;
      to_next_mask_r  <= int_fire_s ? {FETCH_W{1'b0}} : mask_s;
      to_next_int_r   <= int_fire_s;
    end
  end

  assign inst_sram_req_o  = req_s;
  assign inst_sram_addr_o = {pc_q[31:2], 2'b00};
  assign discard_o        = rst_n & inst_sram_data_ok_i & (discard_cnt_r != 3'd0);
  assign to_next_valid_o  = to_next_valid_r;
  assign to_next_pc_o     = to_next_pc_r;
  assign to_next_mask_o   = to_next_mask_r;
  assign to_next_int_o    = to_next_int_r;

endmodule

// File: tb/tb_preif_fetch_ctrl.sv
// Bench for preif_fetch_ctrl: directed stimulus with a packet scoreboard and
// cycle-level checks of the request channel.
module tb_preif_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        intr;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] stall_pc_i;
  logic        excep_en_i;
  logic [31:0] excep_pc_i;
  logic        ertn_en_i;
  logic [31:0] ertn_pc_i;
  logic        refetch_en_i;
  logic [31:0] refetch_pc_i;
  logic        branch_en_i;
  logic [31:0] branch_pc_i;
  logic        flush_i;
  logic        interrupt_en_i;
  logic        cpu_error_i;
  logic        next_allowin_i;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        inst_sram_data_ok_i;
  logic        to_next_valid_o;
  logic [31:0] to_next_pc_o;
  logic [1:0]  to_next_mask_o;
  logic        to_next_int_o;
  logic        discard_o;

  int   chk_cnt   = 0;
  int   pass_cnt  = 0;
  int   pend_data = 0;
  bit   auto_data = 1'b0;
  pkt_t exp_q[$];

  preif_fetch_ctrl #(.FETCH_W(2), .MAX_OUTST(2), .RESET_PC(32'h1c000000)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .stall_pc_i(stall_pc_i),
    .excep_en_i(excep_en_i), .excep_pc_i(excep_pc_i),
    .ertn_en_i(ertn_en_i), .ertn_pc_i(ertn_pc_i),
    .refetch_en_i(refetch_en_i), .refetch_pc_i(refetch_pc_i),
    .branch_en_i(branch_en_i), .branch_pc_i(branch_pc_i),
    .flush_i(flush_i), .interrupt_en_i(interrupt_en_i),
    .cpu_error_i(cpu_error_i), .next_allowin_i(next_allowin_i),
    .inst_sram_req_o(inst_sram_req_o), .inst_sram_addr_o(inst_sram_addr_o),
    .inst_sram_addr_ok_i(inst_sram_addr_ok_i), .inst_sram_data_ok_i(inst_sram_data_ok_i),
    .to_next_valid_o(to_next_valid_o), .to_next_pc_o(to_next_pc_o),
    .to_next_mask_o(to_next_mask_o), .to_next_int_o(to_next_int_o),
    .discard_o(discard_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock: sample handshakes before the edge, then model the data return.
  task automatic step();
    logic hs_seen;
    logic dok_seen;
    #1;
    hs_seen  = inst_sram_req_o & inst_sram_addr_ok_i;
    dok_seen = inst_sram_data_ok_i;
    @(posedge clk);
    #1;
    if (hs_seen) pend_data++;
    if (dok_seen && pend_data > 0) pend_data--;
    if (auto_data) inst_sram_data_ok_i = (pend_data > 0);
  endtask

  task automatic expect_req(input string tag, input logic exp_req, input logic [31:0] exp_addr);
    #1;
    check_eq({tag, "_req"}, {31'd0, inst_sram_req_o}, {31'd0, exp_req});
    if (exp_req) check_eq({tag, "_addr"}, inst_sram_addr_o, exp_addr);
  endtask

  task automatic push_pkt(input logic [31:0] pc, input logic [1:0] mask, input logic intr);
    pkt_t p;
    p.pc = pc; p.mask = mask; p.intr = intr;
    exp_q.push_back(p);
  endtask

  // Scoreboard: every packet handed to IF must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && to_next_valid_o === 1'b1) begin
      check_eq("pkt_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        pkt_t e;
        e = exp_q.pop_front();
        check_eq("pkt_pc", to_next_pc_o, e.pc);
        check_eq("pkt_int", {31'd0, to_next_int_o}, {31'd0, e.intr});
        if (!e.intr) check_eq("pkt_mask", {30'd0, to_next_mask_o}, {30'd0, e.mask});
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; stall_pc_i = 32'h0; excep_en_i = 1'b0; excep_pc_i = 32'h0;
    ertn_en_i = 1'b0; ertn_pc_i = 32'h0; refetch_en_i = 1'b0; refetch_pc_i = 32'h0;
    branch_en_i = 1'b0; branch_pc_i = 32'h0; flush_i = 1'b0; interrupt_en_i = 1'b0;
    cpu_error_i = 1'b0; next_allowin_i = 1'b1; inst_sram_addr_ok_i = 1'b1;
    inst_sram_data_ok_i = 1'b0;
    step(); step();
    #1;
    check_eq("rst_req", {31'd0, inst_sram_req_o}, 32'd0);
    check_eq("rst_addr", inst_sram_addr_o, 32'h1c000000);
    check_eq("rst_valid", {31'd0, to_next_valid_o}, 32'd0);
    check_eq("rst_int", {31'd0, to_next_int_o}, 32'd0);
    check_eq("rst_mask", {30'd0, to_next_mask_o}, 32'd0);
    check_eq("rst_discard", {31'd0, discard_o}, 32'd0);

    // Sequential fetch after reset.
    rst_n = 1'b1; auto_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_req("seq", 1'b1, 32'h1c000000 + 32'(i * 8));
      push_pkt(32'h1c000000 + 32'(i * 8), 2'b11, 1'b0);
      step();
    end

    // Branch into the second lane of a packet.
    branch_en_i = 1'b1; branch_pc_i = 32'h1c000104;
    expect_req("br_cyc", 1'b1, 32'h1c000018);
    step();
    branch_en_i = 1'b0;
    expect_req("br_tgt", 1'b1, 32'h1c000104);
    push_pkt(32'h1c000104, 2'b10, 1'b0);
    step();
    expect_req("br_next", 1'b1, 32'h1c000108);
    push_pkt(32'h1c000108, 2'b11, 1'b0);
    step();

    // Held request while a branch arrives: address frozen, request cancelled.
    inst_sram_addr_ok_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin branch_en_i = 1'b1; branch_pc_i = 32'h1c000200; end
      else branch_en_i = 1'b0;
      expect_req("hold", 1'b1, 32'h1c000110);
      step();
    end
    branch_en_i = 1'b0; inst_sram_addr_ok_i = 1'b1;
    expect_req("hold_ok", 1'b1, 32'h1c000110);
    step();
    expect_req("hold_tgt", 1'b1, 32'h1c000200);
    push_pkt(32'h1c000200, 2'b11, 1'b0);
    step();
    next_allowin_i = 1'b0;
    repeat (4) step();

    // Outstanding limit with no data return.
    auto_data = 1'b0; inst_sram_data_ok_i = 1'b0; next_allowin_i = 1'b1;
    expect_req("lim0", 1'b1, 32'h1c000208); push_pkt(32'h1c000208, 2'b11, 1'b0); step();
    expect_req("lim1", 1'b1, 32'h1c000210); push_pkt(32'h1c000210, 2'b11, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      expect_req("lim_full", 1'b0, 32'h0);
      step();
    end
    inst_sram_data_ok_i = 1'b1;
    expect_req("lim_dok", 1'b0, 32'h0);
    step();
    inst_sram_data_ok_i = 1'b0;
    expect_req("lim_free", 1'b1, 32'h1c000218); push_pkt(32'h1c000218, 2'b11, 1'b0); step();

    // Flush with two outstanding: both returns are discarded.
    flush_i = 1'b1; excep_en_i = 1'b1; excep_pc_i = 32'h1c008000;
    expect_req("fl", 1'b0, 32'h0);
    step();
    flush_i = 1'b0; excep_en_i = 1'b0; next_allowin_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inst_sram_data_ok_i = 1'b1;
      #1 check_eq("fl_discard", {31'd0, discard_o}, 32'd1);
      step();
    end
    inst_sram_data_ok_i = 1'b0; next_allowin_i = 1'b1;
    expect_req("fl_fresh", 1'b1, 32'h1c008000); push_pkt(32'h1c008000, 2'b11, 1'b0); step();
    next_allowin_i = 1'b0; inst_sram_data_ok_i = 1'b1;
    #1 check_eq("fl_keep", {31'd0, discard_o}, 32'd0);
    step();
    inst_sram_data_ok_i = 1'b0; auto_data = 1'b1;

    // Interrupt packet, then interrupt cancelled by a flush.
    interrupt_en_i = 1'b1;
    step();
    interrupt_en_i = 1'b0; next_allowin_i = 1'b1;
    expect_req("int_noreq", 1'b0, 32'h0); push_pkt(32'h1c008008, 2'b00, 1'b1); step();
    expect_req("int_after", 1'b1, 32'h1c008008); push_pkt(32'h1c008008, 2'b11, 1'b0); step();
    next_allowin_i = 1'b0; interrupt_en_i = 1'b1; flush_i = 1'b1;
    excep_en_i = 1'b1; excep_pc_i = 32'h1c009000;
    expect_req("intfl", 1'b0, 32'h0);
    step();
    interrupt_en_i = 1'b0; flush_i = 1'b0; excep_en_i = 1'b0; next_allowin_i = 1'b1;
    expect_req("intfl_next", 1'b1, 32'h1c009000); push_pkt(32'h1c009000, 2'b11, 1'b0); step();

    // Stall outranks a branch; cpu_error blocks new requests.
    stall_i = 1'b1; stall_pc_i = 32'h1c00a004; branch_en_i = 1'b1; branch_pc_i = 32'h1c00b000;
    expect_req("stall", 1'b0, 32'h0);
    step();
    stall_i = 1'b0; branch_en_i = 1'b0;
    expect_req("stall_tgt", 1'b1, 32'h1c00a004); push_pkt(32'h1c00a004, 2'b10, 1'b0); step();
    cpu_error_i = 1'b1;
    expect_req("cpu_err", 1'b0, 32'h0);
    step();
    cpu_error_i = 1'b0; next_allowin_i = 1'b0;
    repeat (4) step();
    check_eq("pkt_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
